// File: rtl/player_pkg.sv
// Shared player-state encoding; imported by the player FSM and by the health/block bookkeeping.
package player_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE         = 4'd0,
    WALK_FWD     = 4'd1,
    WALK_BACK    = 4'd2,
    ATK_STARTUP  = 4'd3,
    ATK_ACTIVE   = 4'd4,
    ATK_RECOVERY = 4'd5,
    DIR_STARTUP  = 4'd6,
    DIR_ACTIVE   = 4'd7,
    DIR_RECOVERY = 4'd8,
    HITSTUN      = 4'd9,
    BLOCKSTUN    = 4'd10,
    DEAD         = 4'd11
  } player_state_e;

  function automatic logic is_hitbox_state(input player_state_e s);
    return (s == ATK_ACTIVE) || (s == DIR_ACTIVE);
  endfunction

  function automatic logic is_dir_state(input player_state_e s);
    return (s == DIR_STARTUP) || (s == DIR_ACTIVE) || (s == DIR_RECOVERY);
  endfunction

endpackage

// File: rtl/player_fsm_frame_timer.sv
// Down-counter advanced only on frame ticks; a load on a tick takes precedence over counting.
module player_fsm_frame_timer #(
  parameter int unsigned Width = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic [Width-1:0] count_o,
  output logic             zero_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (tick_i) begin
      if (load_i) begin
        count_d = load_val_i;
      end else if (count_q != '0) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/player_fsm.sv
// Per-player fighting-game state machine: movement, attacks, stun and KO, stepped on frame ticks.
module player_fsm
  import player_pkg::*;
#(
  parameter int unsigned AtkStartup  = 4,
  parameter int unsigned AtkActive   = 2,
  parameter int unsigned AtkRecovery = 12,
  parameter int unsigned HitstunT    = 15,
  parameter int unsigned BlockstunT  = 10,
  parameter int unsigned CntW        = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_attack,
  input  logic               facing_right,
  input  logic               hit_in,
  input  logic [2:0]         health_in,
  output logic [STATE_W-1:0] state,
  output logic               hitbox_active,
  output logic               dir_attack
);

  player_state_e state_q, state_d;
  logic          attack_prev_q, attack_prev_d;
  logic          hitbox_q, dir_q;
  logic          fwd, back, atk_edge;
  logic          timer_load, timer_zero;
  logic [CntW-1:0] timer_val, timer_cnt;

  assign fwd      = facing_right ? (!btn_left && btn_right) : (btn_left && !btn_right);
  assign back     = facing_right ? (btn_left && !btn_right) : (!btn_left && btn_right);
  assign atk_edge = btn_attack && !attack_prev_q;

  always_comb begin
    state_d       = state_q;
    attack_prev_d = attack_prev_q;
    if (frame_tick) begin
      attack_prev_d = btn_attack;
      if (health_in == 3'd0) begin
        state_d = DEAD;
      end else begin
        case (state_q)
          IDLE, WALK_FWD, WALK_BACK: begin
            if (hit_in)        state_d = back ? BLOCKSTUN : HITSTUN;
            else if (atk_edge) state_d = fwd ? DIR_STARTUP : ATK_STARTUP;
            else if (fwd)      state_d = WALK_FWD;
            else if (back)     state_d = WALK_BACK;
            else               state_d = IDLE;
          end
          ATK_STARTUP:  state_d = hit_in ? HITSTUN : (timer_zero ? ATK_ACTIVE   : state_q);
          ATK_ACTIVE:   state_d = hit_in ? HITSTUN : (timer_zero ? ATK_RECOVERY : state_q);
          ATK_RECOVERY: state_d = hit_in ? HITSTUN : (timer_zero ? IDLE         : state_q);
          DIR_STARTUP:  state_d = hit_in ? HITSTUN : (timer_zero ? DIR_ACTIVE   : state_q);
          DIR_ACTIVE:   state_d = hit_in ? HITSTUN : (timer_zero ? DIR_RECOVERY : state_q);
          DIR_RECOVERY: state_d = hit_in ? HITSTUN : (timer_zero ? IDLE         : state_q);
          // Stuns ignore further hits so the consumer sees exactly one entry per stun.
          HITSTUN, BLOCKSTUN: state_d = timer_zero ? IDLE : state_q;
          DEAD:               state_d = DEAD;
          default:            state_d = IDLE;
        endcase
      end
    end
  end

  // Every timed-state entry is a state change, so loading on change covers all entries.
  always_comb begin
    timer_val = '0;
    case (state_d)
      ATK_STARTUP, DIR_STARTUP:   timer_val = CntW'(AtkStartup - 1);
      ATK_ACTIVE, DIR_ACTIVE:     timer_val = CntW'(AtkActive - 1);
      ATK_RECOVERY, DIR_RECOVERY: timer_val = CntW'(AtkRecovery - 1);
      HITSTUN:                    timer_val = CntW'(HitstunT - 1);
      BLOCKSTUN:                  timer_val = CntW'(BlockstunT - 1);
      default:                    timer_val = '0;
    endcase
  end

  assign timer_load = frame_tick && (state_d != state_q);

  player_fsm_frame_timer #(
    .Width(CntW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .tick_i     (frame_tick),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .count_o    (timer_cnt),
    .zero_o     (timer_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      attack_prev_q <= 1'b1;
      hitbox_q      <= 1'b0;
      dir_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      attack_prev_q <= attack_prev_d;
      hitbox_q      <= is_hitbox_state(state_d);
      dir_q         <= is_dir_state(state_d);
    end
  end

  assign state         = state_q;
  assign hitbox_active = hitbox_q;
  assign dir_attack    = dir_q;

endmodule

// File: tb/tb_player_fsm.sv
// Self-checking bench for player_fsm: scripted frames with a queue of expected {state, hitbox, dir}.
module tb_player_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_attack = 1'b0;
  logic       facing_right = 1'b1;
  logic       hit_in = 1'b0;
  logic [2:0] health_in = 3'd7;
  logic [3:0] state;
  logic       hitbox_active, dir_attack;

  int checks = 0;
  int failures = 0;
  logic [5:0] exp_q[$];

  player_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_attack    (btn_attack),
    .facing_right  (facing_right),
    .hit_in        (hit_in),
    .health_in     (health_in),
    .state         (state),
    .hitbox_active (hitbox_active),
    .dir_attack    (dir_attack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] expect_of(input logic [3:0] s);
    logic hb, da;
    hb = (s == 4'd4) || (s == 4'd7);
    da = (s == 4'd6) || (s == 4'd7) || (s == 4'd8);
    return {s, hb, da};
  endfunction

  // One frame: queue the expected post-tick outputs, clock, then compare.
  task automatic tick(input logic [3:0] s, input string tag);
    logic [5:0] e;
    exp_q.push_back(expect_of(s));
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 8'd1, 8'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {2'b00, state, hitbox_active, dir_attack}, {2'b00, e});
    end
  endtask

  task automatic run(input logic [3:0] s, input int n, input string tag);
    for (int i = 0; i < n; i++) tick(s, tag);
  endtask

  initial begin
    int cnt;
    // Reset with attack held: no attack may fire.
    btn_attack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {4'h0, state}, 8'd0);
    check("reset_outs", {6'h0, hitbox_active, dir_attack}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    run(4'd0, 3, "held_through_reset");
    btn_attack = 1'b0;
    run(4'd0, 1, "release");
    btn_attack = 1'b1;
    run(4'd3, 4, "atk_startup");
    run(4'd4, 2, "atk_active");
    run(4'd5, 12, "atk_recovery");
    run(4'd0, 1, "atk_done");
    btn_attack = 1'b0;

    // Directional attack with forward held.
    btn_right = 1'b1;
    run(4'd1, 1, "walk_fwd");
    btn_attack = 1'b1;
    run(4'd6, 4, "dir_startup");
    run(4'd7, 2, "dir_active");
    run(4'd8, 12, "dir_recovery");
    run(4'd0, 1, "dir_done");
    btn_attack = 1'b0;
    run(4'd1, 1, "walk_again");
    btn_right = 1'b0;
    btn_left = 1'b1;
    run(4'd2, 1, "walk_back");
    btn_left = 1'b0;
    btn_right = 1'b1;
    facing_right = 1'b0;
    run(4'd2, 1, "mirror_back");
    facing_right = 1'b1;
    btn_right = 1'b0;
    run(4'd0, 1, "neutral");

    // Blocked hit while holding back.
    btn_left = 1'b1;
    hit_in = 1'b1;
    run(4'd10, 1, "block_entry");
    hit_in = 1'b0;
    run(4'd10, 9, "blockstun");
    run(4'd0, 1, "block_exit");
    btn_left = 1'b0;
    run(4'd0, 1, "idle");

    // Unblocked hit.
    hit_in = 1'b1;
    run(4'd9, 1, "hit_entry");
    hit_in = 1'b0;
    run(4'd9, 14, "hitstun");
    run(4'd0, 1, "hit_exit");

    // Counter-hit during ATK_ACTIVE, then a re-hit during stun must not extend it.
    btn_attack = 1'b1;
    run(4'd3, 4, "ch_startup");
    run(4'd4, 1, "ch_active");
    hit_in = 1'b1;
    run(4'd9, 1, "counter_hit");
    hit_in = 1'b0;
    run(4'd9, 5, "ch_stun_a");
    hit_in = 1'b1;
    run(4'd9, 1, "ch_rehit");
    hit_in = 1'b0;
    run(4'd9, 8, "ch_stun_b");
    run(4'd0, 1, "ch_exit");
    btn_attack = 1'b0;
    run(4'd0, 1, "ch_idle");

    // KO has priority over a simultaneous hit and is absorbing.
    health_in = 3'd0;
    hit_in = 1'b1;
    run(4'd11, 1, "ko");
    health_in = 3'd5;
    btn_attack = 1'b1;
    btn_right = 1'b1;
    run(4'd11, 3, "dead_absorb");
    hit_in = 1'b0;
    btn_attack = 1'b0;
    btn_right = 1'b0;
    #2 rst = 1'b1;
    #1 check("dead_reset", {4'h0, state}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    run(4'd0, 1, "after_reset");

    // Blockstun with a frame tick every fourth cycle lasts 40 cycles.
    btn_left = 1'b1;
    hit_in = 1'b1;
    run(4'd10, 1, "slow_block_entry");
    hit_in = 1'b0;
    cnt = 1;
    for (int k = 1; k <= 100; k++) begin
      frame_tick = (k % 4 == 0);
      @(posedge clk);
      #1;
      if (state != 4'd10) break;
      cnt++;
    end
    frame_tick = 1'b0;
    check("slow_block_cycles", 8'(cnt), 8'd40);
    check("slow_block_exit", {4'h0, state}, 8'd0);
    btn_left = 1'b0;

    // Asynchronous reset mid-stun.
    hit_in = 1'b1;
    run(4'd9, 1, "stun_for_rst");
    hit_in = 1'b0;
    run(4'd9, 3, "stun_for_rst_b");
    #2 rst = 1'b1;
    #1;
    check("rst_mid_stun", {4'h0, state}, 8'd0);
    check("rst_timer", 8'(dut.timer_cnt), 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset mid-attack drops the hitbox without a clock edge.
    btn_attack = 1'b0;
    run(4'd0, 1, "pre_rst_atk");
    btn_attack = 1'b1;
    run(4'd3, 4, "rst_atk_startup");
    run(4'd4, 1, "rst_atk_active");
    #2 rst = 1'b1;
    #1;
    check("rst_mid_attack", {4'h0, state, hitbox_active, dir_attack}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    check("sb_drained", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
